// File: rtl/maxnet_winner_ctrl.sv
// rtl/maxnet_winner_ctrl.sv - MaxNet termination controller: counts survivors, requests iterations, reports winner
module maxnet_winner_ctrl #(
    parameter int M        = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_ITER = 64,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [M-1:0]     nz_flags,
    input  logic             flags_valid,
    output logic             iter_en,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] winner,
    output logic             winner_valid,
    output logic             timeout,
    output logic [CNT_W-1:0] iter_count
);

    localparam int PW = $clog2(M + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MAX_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [IDX_W-1:0] win_q, win_nx;
    logic             wv_q, wv_nx;
    logic             to_q, to_nx;
    logic             ien_q, ien_nx;
    logic [PW-1:0]    pop;
    logic [IDX_W-1:0] low_idx;

    function automatic logic [PW-1:0] popcount(input logic [M-1:0] v);
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < M; i++) begin
            acc = acc + PW'(v[i]);
        end
        return acc;
    endfunction

    // Scanning from the top down leaves the lowest set index as the result.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [M-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign pop     = popcount(nz_flags);
    assign low_idx = lowest_set(nz_flags);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt_q <= '0;
            win_q <= '0;
            wv_q  <= 1'b0;
            to_q  <= 1'b0;
            ien_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt_q <= cnt_nx;
            win_q <= win_nx;
            wv_q  <= wv_nx;
            to_q  <= to_nx;
            ien_q <= ien_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_q;
        win_nx   = win_q;
        wv_nx    = wv_q;
        to_nx    = to_q;
        ien_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                    win_nx   = '0;
                    wv_nx    = 1'b0;
                    to_nx    = 1'b0;
                    ien_nx   = 1'b1;
                end
            end
            S_RUN: begin
                if (flags_valid) begin
                    cnt_nx = cnt_q + 1'b1;
                    if (pop == PW'(1)) begin
                        state_nx = S_DONE;
                        win_nx   = low_idx;
                        wv_nx    = 1'b1;
                    end else if (pop == '0) begin
                        state_nx = S_DONE;
                        win_nx   = '0;
                        wv_nx    = 1'b0;
                    end else if (cnt_q == LAST_ITER) begin
                        state_nx = S_DONE;
                        win_nx   = low_idx;
                        wv_nx    = 1'b0;
                        to_nx    = 1'b1;
                    end else begin
                        ien_nx = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign iter_en      = ien_q;
    assign busy         = (state == S_RUN);
    assign done         = (state == S_DONE);
    assign winner       = win_q;
    assign winner_valid = wv_q;
    assign timeout      = to_q;
    assign iter_count   = cnt_q;

endmodule

// File: tb/tb_maxnet_winner_ctrl.sv
// tb/tb_maxnet_winner_ctrl.sv - self-checking bench for maxnet_winner_ctrl
module tb_maxnet_winner_ctrl;

    localparam int M        = 4;
    localparam int IDX_W    = 2;
    localparam int MAX_ITER = 4;
    localparam int CNT_W    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [M-1:0]     nz_flags = '0;
    logic             flags_valid = 1'b0;
    logic             iter_en;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] winner;
    logic             winner_valid;
    logic             timeout;
    logic [CNT_W-1:0] iter_count;

    int checks = 0;
    int failures = 0;
    int ien_total = 0;
    int done_total = 0;

    maxnet_winner_ctrl #(
        .M(M), .IDX_W(IDX_W), .MAX_ITER(MAX_ITER), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .nz_flags(nz_flags),
        .flags_valid(flags_valid), .iter_en(iter_en), .busy(busy),
        .done(done), .winner(winner), .winner_valid(winner_valid),
        .timeout(timeout), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 running, 2 reporting.
    int m_phase = 0;
    int m_cnt = 0;
    int m_win = 0;
    int m_wv = 0;
    int m_to = 0;
    int m_ien = 0;

    always @(posedge clk or negedge rst) begin
        int p;
        int low;
        if (!rst) begin
            m_phase <= 0; m_cnt <= 0; m_win <= 0; m_wv <= 0; m_to <= 0; m_ien <= 0;
        end else begin
            m_ien <= 0;
            if (m_phase == 2) begin
                m_phase <= 0;
            end else if (m_phase == 0) begin
                if (start) begin
                    m_phase <= 1; m_cnt <= 0; m_win <= 0; m_wv <= 0; m_to <= 0; m_ien <= 1;
                end
            end else if (flags_valid) begin
                p = $countones(nz_flags);
                low = 0;
                for (int i = M - 1; i >= 0; i--) if (nz_flags[i]) low = i;
                m_cnt <= m_cnt + 1;
                if (p == 1) begin
                    m_phase <= 2; m_win <= low; m_wv <= 1;
                end else if (p == 0) begin
                    m_phase <= 2; m_win <= 0; m_wv <= 0;
                end else if (m_cnt + 1 == MAX_ITER) begin
                    m_phase <= 2; m_win <= low; m_wv <= 0; m_to <= 1;
                end else begin
                    m_ien <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", int'(busy), int'(m_phase == 1));
        check("done", int'(done), int'(m_phase == 2));
        check("iter_en", int'(iter_en), m_ien);
        check("winner", int'(winner), m_win);
        check("winner_valid", int'(winner_valid), m_wv);
        check("timeout", int'(timeout), m_to);
        check("iter_count", int'(iter_count), m_cnt);
        ien_total  <= ien_total + int'(iter_en);
        done_total <= done_total + int'(done);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic sample(input logic [M-1:0] f);
        flags_valid = 1'b1;
        nz_flags = f;
        tick();
        flags_valid = 1'b0;
    endtask

    initial begin
        int snap;
        int n;
        rst = 1'b0;
        start = 1'b1;
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_iter_en", int'(iter_en), 0);
        check("rst_done", int'(done), 0);
        check("rst_iter_count", int'(iter_count), 0);
        start = 1'b0;
        rst = 1'b1;
        tick();

        do_start();
        check("start_busy", int'(busy), 1);
        check("start_iter_en", int'(iter_en), 1);
        sample(4'b1111);
        check("win_ien1", int'(iter_en), 1);
        sample(4'b0110);
        check("win_ien2", int'(iter_en), 1);
        sample(4'b0100);
        check("win_done", int'(done), 1);
        check("win_winner", int'(winner), 2);
        check("win_wv", int'(winner_valid), 1);
        check("win_timeout", int'(timeout), 0);
        check("win_count", int'(iter_count), 3);
        tick();
        check("win_hold_winner", int'(winner), 2);
        check("win_hold_busy", int'(busy), 0);

        do_start();
        sample(4'b0000);
        check("die_done", int'(done), 1);
        check("die_winner", int'(winner), 0);
        check("die_wv", int'(winner_valid), 0);
        check("die_timeout", int'(timeout), 0);
        check("die_count", int'(iter_count), 1);
        tick();

        snap = ien_total;
        do_start();
        repeat (4) sample(4'b0011);
        check("to_done", int'(done), 1);
        check("to_timeout", int'(timeout), 1);
        check("to_winner", int'(winner), 0);
        check("to_wv", int'(winner_valid), 0);
        check("to_count", int'(iter_count), 4);
        tick();
        check("to_ien_pulses", ien_total - snap, 4);

        do_start();
        tick();
        snap = ien_total;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        check("stall_ien", ien_total - snap, 0);
        check("stall_busy", int'(busy), 1);
        check("stall_count", int'(iter_count), 0);
        sample(4'b1000);
        check("stall_done", int'(done), 1);
        check("stall_winner", int'(winner), 3);
        check("stall_wv", int'(winner_valid), 1);
        tick();

        for (int run = 0; run < 30; run++) begin
            do_start();
            n = 0;
            while (!done && n < 60) begin
                flags_valid = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 3))
                    0: nz_flags = 4'(1 << $urandom_range(0, M - 1));
                    1: nz_flags = 4'b0011 << $urandom_range(0, 2);
                    default: nz_flags = 4'($urandom_range(0, 15));
                endcase
                start = ($urandom_range(0, 7) == 0);
                tick();
                n++;
            end
            flags_valid = 1'b0;
            start = 1'b0;
            if (!done) check("rand_done_reached", 0, 1);
            tick();
        end

        do_start();
        sample(4'b1111);
        sample(4'b1111);
        snap = done_total;
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_iter_en", int'(iter_en), 0);
        check("arst_done", int'(done), 0);
        check("arst_count", int'(iter_count), 0);
        check("arst_winner", int'(winner), 0);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        check("arst_no_done", done_total - snap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maxnet_winner_ctrl.md
Name: maxnet_winner_ctrl

Overview:
- Sequential termination controller that sits directly downstream of the per-neuron OR-reduction stage in the MaxNet datapath.
- Each iteration it receives one "value is nonzero" flag per neuron and counts the surviving neurons.
- It requests further iterations until exactly one neuron survives, all neurons die, or an iteration limit is hit.
- It then reports the winner index and the termination cause to the top-level controller.

Parameters:
- M, 4, number of neurons (number of nonzero flags per iteration); M >= 2.
- IDX_W, 2, width of winner index; must satisfy 2^IDX_W >= M.
- MAX_ITER, 64, maximum iterations before forced termination; MAX_ITER >= 1.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > MAX_ITER.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- start  input  1  one-cycle pulse; begins a competition
- nz_flags  input  M  per-neuron nonzero flags for the current iteration; bit i = neuron i
- flags_valid  input  1  nz_flags valid this cycle
- iter_en  output  1  one-cycle pulse requesting the datapath to compute one iteration
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse on termination
- winner  output  IDX_W  index of surviving neuron
- winner_valid  output  1  winner holds a legal single survivor
- timeout  output  1  last run ended by MAX_ITER
- iter_count  output  CNT_W  flags_valid samples consumed in current/last run

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0, including iter_count, winner, winner_valid and timeout.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN next cycle.
  - On that edge, clear iter_count, winner_valid and timeout; winner -> 0.
  - flags_valid is ignored.
- On entering RUN, iter_en pulses high for exactly one cycle (the first RUN cycle). busy=1 throughout RUN.
- RUN, flags_valid=1: compute P = popcount(nz_flags), full width, no saturation. Evaluate the following in priority order.
  - P==1 -> DONE; winner <= index of the set bit; winner_valid <= 1.
  - P==0 -> DONE; winner_valid <= 0; winner <= 0.
  - iter_count==MAX_ITER-1 (and P>=2) -> DONE; timeout <= 1; winner <= lowest-index set bit; winner_valid <= 0.
  - Otherwise (P>=2): stay in RUN; iter_en pulses on the next cycle.
  - In every case above, iter_count increments by 1.
- RUN, flags_valid=0: hold state and counters; no iter_en.
- start while in RUN or DONE is ignored.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE unconditionally. flags_valid in DONE is ignored.
- After done, winner, winner_valid, timeout and iter_count hold until the next accepted start.
- Latency: done asserts the cycle after the terminating flags_valid sample. iter_en asserts the cycle after each non-terminating sample.
- The counter never wraps, because iter_count is bounded by MAX_ITER.
- Reset mid-RUN: immediate return to IDLE with all outputs 0. No done pulse.
- Winner encoding for P==1: priority encoder, lowest index wins. The encoder is applied to nz_flags as sampled.

Test Plan:
- Reset with start held: rst low, start=1 -> state IDLE, all outputs 0. After rst is released, a start pulse gives busy=1 and iter_en=1 one cycle later.
- Three-iteration win, M=4:
  - start; flags 1111, 0110, 0100 each on flags_valid.
  - Required: iter_en pulse after each of the first two samples.
  - One cycle after the third sample: done=1, winner=2, winner_valid=1, timeout=0, iter_count=3.
- All die: start; flags 0000 on the first sample -> done next cycle; winner_valid=0, winner=0, timeout=0, iter_count=1.
- Timeout with MAX_ITER=4: start; flags 0011 four times -> done after the fourth sample; timeout=1, winner=0, winner_valid=0, iter_count=4. Exactly 4 iter_en pulses in total.
- Stall and ignored start:
  - In RUN, flags_valid held low 5 cycles with start pulsed -> no state change, no extra iter_en, iter_count unchanged.
  - A subsequent sample of 1000 -> done, winner=3, winner_valid=1.
- Async reset mid-run: after 2 samples of 1111, rst low between clock edges -> outputs 0 immediately. No done pulse.
